// File: rtl/exotiny_conmon.sv
// Console monitor: watches strobed console bytes for pass/fail signatures, runs an idle
// watchdog, and captures every accepted byte in a show-ahead FIFO for later readout.
module exotiny_conmon #(
  parameter int unsigned       DEPTH    = 16,
  parameter int unsigned       HIST     = 4,
  parameter logic [HIST*8-1:0] PASS_PAT = (HIST*8)'({"D", "O", "N", "E"}),
  parameter int unsigned       PASS_LEN = 4,
  parameter logic [HIST*8-1:0] FAIL_PAT = (HIST*8)'({"E", "R", "R"}),
  parameter int unsigned       FAIL_LEN = 3,
  parameter logic [31:0]       TIMEOUT  = 32'd0
) (
  input  logic                         clk_i,
  input  logic                         rst_in,
  input  logic                         sel_i,
  input  logic                         stb_i,
  input  logic [7:0]                   wdat_i,
  input  logic                         clear_i,
  input  logic                         rd_i,
  output logic [7:0]                   rd_dat_o,
  output logic                         rd_vld_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         tmo_o,
  output logic                         ovf_o
);

  localparam int unsigned HW   = HIST * 8;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Only the low PASS_LEN / FAIL_LEN bytes of the history take part in a match.
  localparam logic [HW-1:0] PassMask = {HW{1'b1}} >> (HW - PASS_LEN * 8);
  localparam logic [HW-1:0] FailMask = {HW{1'b1}} >> (HW - FAIL_LEN * 8);

  typedef enum logic [1:0] {StRun, StDone, StErr, StTmo} state_e;

  state_e          state_q, state_d;
  logic            stb_q;
  logic [HW-1:0]   hist_q, hist_d, hist_shift;
  logic [31:0]     wdog_q, wdog_d, wdog_inc;
  logic            accept, pass_hit, fail_hit;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q;
  logic            full, empty, push, pop, ovf_set;

  // Edge-detect the strobe so a held strobe yields a single byte.
  assign accept = sel_i & stb_i & ~stb_q;

  assign hist_shift = (hist_q << 8) | HW'(wdat_i);
  assign pass_hit   = ((hist_shift ^ PASS_PAT) & PassMask) == '0;
  assign fail_hit   = ((hist_shift ^ FAIL_PAT) & FailMask) == '0;
  assign wdog_inc   = wdog_q + 32'd1;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    wdog_d  = wdog_q;
    if (clear_i) begin
      state_d = StRun;
      hist_d  = '0;
      wdog_d  = '0;
    end else if (state_q == StRun) begin
      if (accept) begin
        hist_d = hist_shift;
        wdog_d = '0;
        if (fail_hit) begin
          state_d = StErr;
        end else if (pass_hit) begin
          state_d = StDone;
        end
      end else if (TIMEOUT != 32'd0) begin
        wdog_d = wdog_inc;
        if (wdog_inc == TIMEOUT) begin
          state_d = StTmo;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StRun;
      stb_q   <= 1'b0;
      hist_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_i;
      hist_q  <= hist_d;
      wdog_q  <= wdog_d;
    end
  end

  // Capture FIFO; a pop frees the slot the same cycle, so push+pop when full is legal.
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd_i & ~empty & ~clear_i;
  assign push    = accept & (~full | pop) & ~clear_i;
  assign ovf_set = accept & full & ~pop & ~clear_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wdat_i;
    end
  end

  assign rd_dat_o = mem_q[rptr_q];
  assign rd_vld_o = ~empty;
  assign count_o  = count_q;
  assign done_o   = (state_q == StDone);
  assign err_o    = (state_q == StErr);
  assign tmo_o    = (state_q == StTmo);
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_exotiny_conmon.sv
// Directed bench for exotiny_conmon: a default instance plus a TIMEOUT=50 instance.
module tb_exotiny_conmon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0, stb = 1'b0, clear = 1'b0, rd = 1'b0;
  logic       sel2 = 1'b0, stb2 = 1'b0;
  logic [7:0] wdat = 8'h00;

  logic [7:0] rd_dat, t_rd_dat;
  logic       rd_vld, done, err, tmo, ovf;
  logic       t_rd_vld, t_done, t_err, t_tmo, t_ovf;
  logic [4:0] count, t_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exotiny_conmon dut (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .sel_i   (sel),
    .stb_i   (stb),
    .wdat_i  (wdat),
    .clear_i (clear),
    .rd_i    (rd),
    .rd_dat_o(rd_dat),
    .rd_vld_o(rd_vld),
    .count_o (count),
    .done_o  (done),
    .err_o   (err),
    .tmo_o   (tmo),
    .ovf_o   (ovf)
  );

  exotiny_conmon #(.TIMEOUT(32'd50)) dut_t (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .sel_i   (sel2),
    .stb_i   (stb2),
    .wdat_i  (wdat),
    .clear_i (1'b0),
    .rd_i    (1'b0),
    .rd_dat_o(t_rd_dat),
    .rd_vld_o(t_rd_vld),
    .count_o (t_count),
    .done_o  (t_done),
    .err_o   (t_err),
    .tmo_o   (t_tmo),
    .ovf_o   (t_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    sel = 1'b0; stb = 1'b0; clear = 1'b0; rd = 1'b0; sel2 = 1'b0; stb2 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    sel = 1'b1; wdat = b; stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    send(8'h11);
    send(8'h22);
    rd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_async_count: got %0d want 0", count); end
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_async_vld: got %b want 0", rd_vld); end
    checks++; if ({done, err, tmo, ovf} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {done, err, tmo, ovf});
    end
    reset_dut();
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_release_count: got %0d want 0", count); end
  endtask

  task automatic test_done();
    logic [7:0] exp [4] = '{8'h44, 8'h4F, 8'h4E, 8'h45};
    reset_dut();
    send("D"); send("O"); send("N");
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early: got %b want 0", done); end
    sel = 1'b1; wdat = "E"; stb = 1'b1;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_latency: got %b want 1", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL done_err: got %b want 0", err); end
    stb = 1'b0;
    tick();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL done_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_dat !== exp[i] || rd_vld !== 1'b1) begin
        errors++; $display("FAIL done_pop%0d: got %h/%b want %h/1", i, rd_dat, rd_vld, exp[i]);
      end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL done_empty: got %b want 0", rd_vld); end
  endtask

  task automatic test_err();
    reset_dut();
    send("x"); send("E"); send("R");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
    send("R");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    send("D"); send("O"); send("N"); send("E");
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL err_count: got %0d want 8", count); end
    checks++; if ({err, done} !== 2'b10) begin
      errors++; $display("FAIL err_terminal: got err/done %b want 10", {err, done});
    end
  endtask

  task automatic test_held();
    reset_dut();
    sel = 1'b1; wdat = 8'h41; stb = 1'b1;
    repeat (10) tick();
    stb = 1'b0;
    tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL held_count: got %0d want 1", count); end
    checks++; if (rd_dat !== 8'h41) begin errors++; $display("FAIL held_data: got %h want 41", rd_dat); end
  endtask

  task automatic test_underflow();
    reset_dut();
    rd = 1'b1; tick(); tick(); rd = 1'b0;
    checks++; if (count !== 5'd0 || rd_vld !== 1'b0) begin
      errors++; $display("FAIL underflow_empty: got %0d/%b want 0/0", count, rd_vld);
    end
    send(8'h5A);
    checks++; if (count !== 5'd1 || rd_dat !== 8'h5A) begin
      errors++; $display("FAIL underflow_push: got %0d/%h want 1/5a", count, rd_dat);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 17; i++) send(8'(i));
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_dat !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, rd_dat, 8'(i)); end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    checks++; if (rd_vld !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got vld/ovf %b%b want 01", rd_vld, ovf);
    end
    reset_dut();
    for (int i = 0; i < 16; i++) send(8'(i + 32));
    sel = 1'b1; wdat = 8'hAA; stb = 1'b1; rd = 1'b1;
    tick();
    stb = 1'b0; rd = 1'b0;
    tick();
    checks++; if (count !== 5'd16 || ovf !== 1'b0) begin
      errors++; $display("FAIL full_pushpop: got %0d/%b want 16/0", count, ovf);
    end
    checks++; if (rd_dat !== 8'h21) begin errors++; $display("FAIL full_pushpop_head: got %h want 21", rd_dat); end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) send(8'(r * 16 + i));
      for (int i = 0; i < 10; i++) begin
        checks++; if (rd_dat !== 8'(r * 16 + i)) begin
          errors++; $display("FAIL wrap_r%0d_%0d: got %h want %h", r, i, rd_dat, 8'(r * 16 + i));
        end
        rd = 1'b1; tick(); rd = 1'b0;
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    repeat (49) tick();
    checks++; if (t_tmo !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", t_tmo); end
    tick();
    checks++; if (t_tmo !== 1'b1) begin errors++; $display("FAIL tmo_at50: got %b want 1", t_tmo); end
    reset_dut();
    repeat (48) tick();
    sel2 = 1'b1; stb2 = 1'b1;
    tick();
    stb2 = 1'b0;
    tick();
    checks++; if (t_tmo !== 1'b0) begin errors++; $display("FAIL tmo_restart: got %b want 0", t_tmo); end
    repeat (48) tick();
    checks++; if (t_tmo !== 1'b0) begin errors++; $display("FAIL tmo_restart_early: got %b want 0", t_tmo); end
    tick();
    checks++; if (t_tmo !== 1'b1) begin errors++; $display("FAIL tmo_restart_fire: got %b want 1", t_tmo); end
    checks++; if (t_count !== 5'd1) begin errors++; $display("FAIL tmo_count: got %0d want 1", t_count); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_disabled: got %b want 0", tmo); end
  endtask

  task automatic test_clear();
    reset_dut();
    send("D"); send("O"); send("N"); send("E");
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_pre_done: got %b want 1", done); end
    clear = 1'b1; sel = 1'b1; wdat = 8'h77; stb = 1'b1;
    tick();
    clear = 1'b0; stb = 1'b0;
    tick();
    checks++; if ({done, err, tmo, ovf} !== 4'b0) begin
      errors++; $display("FAIL clear_flags: got %b want 0000", {done, err, tmo, ovf});
    end
    checks++; if (count !== 5'd0 || rd_vld !== 1'b0) begin
      errors++; $display("FAIL clear_fifo: got %0d/%b want 0/0", count, rd_vld);
    end
    send("E"); send("R"); send("R");
    checks++; if (err !== 1'b1 || count !== 5'd3) begin
      errors++; $display("FAIL clear_then_err: got %b/%0d want 1/3", err, count);
    end
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    send("E"); send("R");
    reset_dut();
    send("R");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midreset_hist: got %b want 0", err); end
    send("E"); send("R"); send("R");
    checks++; if (err !== 1'b1 || count !== 5'd4) begin
      errors++; $display("FAIL midreset_err: got %b/%0d want 1/4", err, count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_done();
    test_err();
    test_held();
    test_underflow();
    test_overflow();
    test_wrap();
    test_timeout();
    test_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exotiny_conmon.md
EXOTINY_CONMON -- requirements
Module: exotiny_conmon

Interface
REQ-001 SHALL have parameter DEPTH, default 16: capture FIFO entries; power of two, >=2.
REQ-002 SHALL have parameter HIST, default 4: history length in bytes, 1..8.
REQ-003 SHALL have parameter PASS_PAT, default {"D","O","N","E"}: HIST*8-bit pass pattern, right-aligned.
REQ-004 SHALL have parameter PASS_LEN, default 4: significant pass-pattern bytes, 1..HIST.
REQ-005 SHALL have parameter FAIL_PAT, default {"E","R","R"}: HIST*8-bit fail pattern, right-aligned.
REQ-006 SHALL have parameter FAIL_LEN, default 3: significant fail-pattern bytes, 1..HIST.
REQ-007 SHALL have parameter TIMEOUT, default 0: 32-bit idle-cycle limit; 0 disables the watchdog.
REQ-008 clk_i  in  1  single clock; all state updates on rising edge.
REQ-009 rst_in  in  1  reset, asynchronous, active-low.
REQ-010 sel_i  in  1  console address selected.
REQ-011 stb_i  in  1  bus data strobe.
REQ-012 wdat_i  in  8  write byte.
REQ-013 clear_i  in  1  synchronous clear of state, history, FIFO, flags.
REQ-014 rd_i  in  1  FIFO pop request.
REQ-015 rd_dat_o  out  8  FIFO head byte (show-ahead).
REQ-016 rd_vld_o  out  1  FIFO non-empty.
REQ-017 count_o  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-018 done_o / err_o / tmo_o  out  1 each  state is DONE / ERR / TMO.
REQ-019 ovf_o  out  1  sticky FIFO overflow.

Function
REQ-020 SHALL register stb_q <= stb_i each cycle; accept = sel_i & stb_i & ~stb_q.
REQ-021 SHALL accept at most one byte per strobe rising edge; held stb_i SHALL NOT re-accept.
REQ-022 On accept in RUN, history SHALL shift {hist[HIST*8-9:0], wdat_i} at that edge.
REQ-023 Match SHALL compare the low PASS_LEN/FAIL_LEN bytes of the post-shift history value, evaluated on the accepting edge.
REQ-024 FSM states RUN, DONE, ERR, TMO; RUN->ERR on fail match; RUN->DONE on pass match; fail takes priority when both match.
REQ-025 done_o/err_o SHALL assert in the cycle following the accepting edge (one-edge latency).
REQ-026 Watchdog SHALL count cycles in RUN, reset to 0 on every accept; RUN->TMO when count reaches TIMEOUT (TIMEOUT>0); accept on that same edge wins (stays RUN/matches).
REQ-027 DONE, ERR, TMO SHALL be terminal until clear_i or reset; history and watchdog frozen there.
REQ-028 Every accept, in any state, SHALL push wdat_i into the FIFO unless full.
REQ-029 Push when full and no pop SHALL be dropped and set ovf_o, sticky.
REQ-030 Pop when rd_i & rd_vld_o; rd_i when empty SHALL be ignored.
REQ-031 Simultaneous push and pop SHALL both occur, count unchanged, also when full (no overflow).
REQ-032 rd_dat_o SHALL be the oldest byte; defined only while rd_vld_o=1.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH.
REQ-034 clear_i SHALL override accept and rd_i in its cycle: state RUN, history 0, watchdog 0, FIFO empty, ovf_o 0.

Reset
REQ-035 rst_in low SHALL immediately force: state RUN, stb_q 0, history 0, watchdog 0, FIFO empty, count_o 0, rd_vld_o 0, done_o/err_o/tmo_o/ovf_o 0.
REQ-036 Reset mid-byte or mid-pop SHALL discard all in-flight data; first accept after release uses an empty history.

Verification
REQ-037 Strobe "D","O","N","E" (sel_i=1, one rising edge each) -> done_o=1 one cycle after 4th edge; FIFO count 4, pops return 0x44,0x4F,0x4E,0x45.
REQ-038 Strobe "x","E","R","R" -> err_o=1 after 4th edge; further bytes -> FIFO grows, err_o stays, done_o never.
REQ-039 stb_i held high 10 cycles with sel_i=1, wdat_i=0x41 -> exactly one accept, count_o=1.
REQ-040 TIMEOUT=50, no strobes -> tmo_o=1 exactly 50 cycles after reset release; byte on cycle 49 restarts count.
REQ-041 DEPTH=16, 17 accepts no pops -> count_o=16, ovf_o=1, 17th byte lost; 17th accept with rd_i=1 -> count 16, ovf_o=0.
REQ-042 After done_o, pulse clear_i -> all flags 0, count_o=0; then "ERR" -> err_o=1.
